// File: rtl/popeye_roh_pkg.sv
// Shared types and constants for the Popeye bus-request / DMA slot sequencer.
package popeye_roh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // {BI_n,AI_n} == 2'b00 means H[1:0] == 3, the last pixel of a 4-pixel slot.
    localparam logic [1:0] SLOT_PHASE = 2'b00;
    localparam logic [7:0] SLOT_MAX   = 8'd255;

endpackage

// File: rtl/popeye_roh_slot.sv
// Edge detector for the pixel phase and vertical blank: one-clk slot,
// vb_fall and vb_rise pulses derived from the slow H/V counter inputs.
module popeye_roh_slot
    import popeye_roh_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_vb_n,
    input  logic [1:0] i_phase,
    input  logic       i_hbd_n,
    output logic       o_slot,
    output logic       o_vb_fall,
    output logic       o_vb_rise
);

    logic       r_vb_n_q;
    logic [1:0] r_phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vb_n_q  <= 1'b1;
            r_phase_q <= 2'b11;
        end else begin
            r_vb_n_q  <= i_vb_n;
            r_phase_q <= i_phase;
        end
    end

    // Each pixel lasts several clks, so only the entry into the slot phase counts.
    assign o_slot    = (i_phase == SLOT_PHASE) && (r_phase_q != SLOT_PHASE) && !i_hbd_n;
    assign o_vb_fall = r_vb_n_q && !i_vb_n;
    assign o_vb_rise = !r_vb_n_q && i_vb_n;

endmodule

// File: rtl/popeye_roh.sv
// Bus-request and DMA slot sequencer: requests the CPU bus during vertical
// blank and issues one transfer strobe per 4-pixel slot while granted.
//
// state | meaning
// IDLE  | bus released, waiting for vertical blank to start
// REQ   | bus requested, waiting for busak
// XFER  | bus granted, strobing one transfer per slot
// DONE  | table finished or 255 slots used, waiting for blank to end
module popeye_roh
    import popeye_roh_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic VB_n,
    input  logic AI_n,
    input  logic BI_n,
    input  logic HBD_n,
    input  logic busak,
    input  logic DM10,
    output logic MR_n,
    output logic ROHVCK,
    output logic ROHVS
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_mr_n;
    logic       r_vck;
    logic       r_vs;
    logic       w_mr_n_nxt;
    logic       w_vck_nxt;
    logic       w_vs_nxt;
    logic       w_slot;
    logic       w_vb_fall;
    logic       w_vb_rise;

    popeye_roh_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .i_vb_n    (VB_n),
        .i_phase   ({BI_n, AI_n}),
        .i_hbd_n   (HBD_n),
        .o_slot    (w_slot),
        .o_vb_fall (w_vb_fall),
        .o_vb_rise (w_vb_rise)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_vck_nxt   = 1'b0;
        w_vs_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vb_fall) begin
                    w_state_nxt = ST_REQ;
                    w_count_nxt = '0;
                end
            end
            ST_REQ: begin
                if (w_vb_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (busak) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                // Abort beats a lost grant, which beats a coincident slot.
                if (w_vb_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (!busak) begin
                    w_state_nxt = ST_REQ;
                end else if (w_slot) begin
                    w_vck_nxt   = 1'b1;
                    w_count_nxt = r_count + 8'd1;
                    if (DM10) begin
                        w_vs_nxt    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (w_count_nxt == SLOT_MAX) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_vb_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_mr_n_nxt = !((w_state_nxt == ST_REQ) || (w_state_nxt == ST_XFER));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mr_n  <= 1'b1;
            r_vck   <= 1'b0;
            r_vs    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_mr_n  <= w_mr_n_nxt;
            r_vck   <= w_vck_nxt;
            r_vs    <= w_vs_nxt;
        end
    end

    assign MR_n   = r_mr_n;
    assign ROHVCK = r_vck;
    assign ROHVS  = r_vs;

endmodule

// File: tb/tb_popeye_roh.sv
// Scoreboard bench for popeye_roh: a behavioural model predicts each cycle's
// outputs into a queue; an independent monitor pops and compares them.
module tb_popeye_roh;

    logic clk = 1'b0;
    logic rst, VB_n, AI_n, BI_n, HBD_n, busak, DM10;
    logic MR_n, ROHVCK, ROHVS;

    always #5 clk = ~clk;

    popeye_roh dut (
        .clk    (clk),
        .rst    (rst),
        .VB_n   (VB_n),
        .AI_n   (AI_n),
        .BI_n   (BI_n),
        .HBD_n  (HBD_n),
        .busak  (busak),
        .DM10   (DM10),
        .MR_n   (MR_n),
        .ROHVCK (ROHVCK),
        .ROHVS  (ROHVS)
    );

    typedef struct {
        int unsigned tag;
        logic        mr_n;
        logic        vck;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;
    int vck_total = 0;
    int vs_total = 0;

    always @(posedge clk) cyc++;

    // Model: what the sequencer should be doing, in plain terms.
    localparam int M_IDLE = 0, M_WAIT = 1, M_XFER = 2, M_FIN = 3;
    int       m_mode;
    int       m_count;
    bit       m_vb_prev;
    bit [1:0] m_ph_prev;

    logic [1:0] h = 2'd0;
    int sub = 0;
    int dm10_at = 0;
    bit rise_on_slot = 1'b0;

    function automatic void model_step(output exp_t e);
        bit slot, fall, rise;
        e.tag = cyc;
        e.vck = 1'b0;
        e.vs  = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_vb_prev = 1'b1; m_ph_prev = 2'b11;
            e.mr_n = 1'b1;
            return;
        end
        slot = ({BI_n, AI_n} == 2'b00) && (m_ph_prev != 2'b00) && !HBD_n;
        fall = m_vb_prev && !VB_n;
        rise = !m_vb_prev && VB_n;
        case (m_mode)
            M_IDLE: if (fall) begin m_mode = M_WAIT; m_count = 0; end
            M_WAIT: if (rise) m_mode = M_IDLE; else if (busak) m_mode = M_XFER;
            M_XFER: begin
                if (rise) m_mode = M_IDLE;
                else if (!busak) m_mode = M_WAIT;
                else if (slot) begin
                    e.vck = 1'b1;
                    m_count++;
                    if (DM10) begin e.vs = 1'b1; m_mode = M_FIN; end
                    else if (m_count == 255) m_mode = M_FIN;
                end
            end
            default: if (rise) m_mode = M_IDLE;
        endcase
        e.mr_n = !(m_mode == M_WAIT || m_mode == M_XFER);
        m_vb_prev = VB_n;
        m_ph_prev = {BI_n, AI_n};
    endfunction

    // Applies current inputs, predicts the result of the next edge, then waits.
    task automatic drive_cycle();
        exp_t e;
        sub++;
        if (sub == 4) begin sub = 0; h = h + 2'd1; end
        AI_n = ~h[0];
        BI_n = ~h[1];
        if (rise_on_slot && m_mode == M_XFER && busak && !HBD_n && h == 2'd3 && sub == 0) begin
            VB_n = 1'b1;
            DM10 = 1'b1;
            rise_on_slot = 1'b0;
        end else begin
            DM10 = (dm10_at != 0) && (m_count == dm10_at - 1);
        end
        model_step(e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_count(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (MR_n !== e.mr_n || ROHVCK !== e.vck || ROHVS !== e.vs) begin
                failures++;
                $display("FAIL outputs cyc=%0d actual MR_n=%b ROHVCK=%b ROHVS=%b required MR_n=%b ROHVCK=%b ROHVS=%b",
                         cyc, MR_n, ROHVCK, ROHVS, e.mr_n, e.vck, e.vs);
            end
        end
        if (ROHVCK === 1'b1) vck_total++;
        if (ROHVS === 1'b1) vs_total++;
    end

    initial begin
        int v0, s0;
        rst = 1'b1; VB_n = 1'b1; HBD_n = 1'b0; busak = 1'b0; DM10 = 1'b0;
        AI_n = 1'b1; BI_n = 1'b1;
        repeat (3) drive_cycle();
        rst = 1'b0;

        // Idle with VB_n high.
        v0 = vck_total; s0 = vs_total;
        repeat (40) drive_cycle();
        check_count("idle_vck", vck_total - v0, 0);
        check_count("idle_vs", vs_total - s0, 0);

        // Blank, grant after 10 clks, end-of-table at the 5th slot.
        v0 = vck_total; s0 = vs_total;
        dm10_at = 5; VB_n = 1'b0;
        repeat (10) drive_cycle();
        check_count("pre_grant_vck", vck_total - v0, 0);
        busak = 1'b1;
        repeat (140) drive_cycle();
        check_count("dm10_5_vck", vck_total - v0, 5);
        check_count("dm10_5_vs", vs_total - s0, 1);
        check_count("dm10_5_mr_n", int'(MR_n), 1);
        VB_n = 1'b1; busak = 1'b0;
        repeat (30) drive_cycle();
        check_count("after_done_vck", vck_total - v0, 5);

        // Grant lost for 40 clks mid-transfer; counter must survive the gap.
        v0 = vck_total; s0 = vs_total;
        dm10_at = 7; VB_n = 1'b0; busak = 1'b1;
        repeat (50) drive_cycle();
        busak = 1'b0;
        repeat (40) drive_cycle();
        busak = 1'b1;
        repeat (140) drive_cycle();
        check_count("gap_vck", vck_total - v0, 7);
        check_count("gap_vs", vs_total - s0, 1);
        VB_n = 1'b1;
        repeat (20) drive_cycle();

        // Window closed, then blank ends exactly on a DM10 slot.
        dm10_at = 0; VB_n = 1'b0; busak = 1'b1;
        repeat (40) drive_cycle();
        v0 = vck_total; s0 = vs_total;
        HBD_n = 1'b1;
        repeat (48) drive_cycle();
        check_count("hbd_closed_vck", vck_total - v0, 0);
        HBD_n = 1'b0; rise_on_slot = 1'b1;
        repeat (40) drive_cycle();
        check_count("abort_vs", vs_total - s0, 0);
        check_count("abort_mr_n", int'(MR_n), 1);
        rise_on_slot = 1'b0; busak = 1'b0;
        repeat (10) drive_cycle();

        // DM10 never asserted: the slot count saturates at 255.
        v0 = vck_total; s0 = vs_total;
        VB_n = 1'b0; busak = 1'b1;
        repeat (255 * 16 + 40) drive_cycle();
        check_count("max_vck", vck_total - v0, 255);
        check_count("max_vs", vs_total - s0, 0);
        check_count("max_mr_n", int'(MR_n), 1);
        VB_n = 1'b1; busak = 1'b0;
        repeat (10) drive_cycle();

        // Reset in the middle of a transfer.
        VB_n = 1'b0; busak = 1'b1;
        repeat (60) drive_cycle();
        rst = 1'b1;
        repeat (2) drive_cycle();
        rst = 1'b0;
        repeat (40) drive_cycle();
        VB_n = 1'b1; busak = 1'b0;
        repeat (20) drive_cycle();

        // Randomized blanks with flickering grant and window.
        for (int it = 0; it < 6; it++) begin
            dm10_at = $urandom_range(1, 12);
            VB_n = 1'b0;
            for (int c = 0; c < 260; c++) begin
                busak = ($urandom_range(0, 9) != 0);
                HBD_n = ($urandom_range(0, 7) == 0);
                drive_cycle();
            end
            VB_n = 1'b1; HBD_n = 1'b0;
            repeat ($urandom_range(5, 30)) drive_cycle();
        end

        @(negedge clk);
        @(negedge clk);
        check_count("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
